// File: rtl/posit_pkg.sv
// Shared posit helpers: field widths, the NaR bit pattern and a decoded-field
// record sized for the default 16-bit / ES=3 configuration.
package posit_pkg;

  localparam int POSIT_N  = 16;
  localparam int POSIT_ES = 3;

  // Width of the signed combined scale k*2^ES + e.
  function automatic int scale_w(input int n, input int es);
    return $clog2(n) + es + 1;
  endfunction

  // Width of the left-aligned fraction; never narrower than one bit.
  function automatic int frac_w(input int n, input int es);
    return (n - 3 - es > 0) ? n - 3 - es : 1;
  endfunction

  // NaR is a one in the sign position followed by zeros (valid for n <= 64).
  function automatic logic [63:0] nar_pattern(input int n);
    return 64'd1 << (n - 1);
  endfunction

  localparam int POSIT_SCALE_W = scale_w(POSIT_N, POSIT_ES);
  localparam int POSIT_FRAC_W  = frac_w(POSIT_N, POSIT_ES);

  typedef struct packed {
    logic                            sign;
    logic                            zero;
    logic                            nar;
    logic signed [POSIT_SCALE_W-1:0] scale;
    logic [POSIT_FRAC_W-1:0]         frac;
  } posit_fields_t;

endpackage

// File: rtl/posit_regime_lzd.sv
// Leading run detector for the posit regime field. Looks at the magnitude word
// below its top bit, measures the run of identical bits, and returns the bits
// that follow the run terminator shifted up to the MSB. Purely combinational.
module posit_regime_lzd
  import posit_pkg::*;
#(
  parameter  int N    = 16,
  localparam int RL_W = $clog2(N)
) (
  input  logic [N-1:0]    abs_in,
  output logic [RL_W-1:0] run_len,
  output logic            polarity,
  output logic [N-2:0]    remainder
);

  logic [N-2:0] body;
  logic [N-2:0] diff;
  logic [RL_W:0] shamt;
  logic unused_msb;

  // The magnitude's top bit is only set for NaR, which the caller flags separately.
  assign unused_msb = abs_in[N-1];
  assign body       = abs_in[N-2:0];
  assign polarity   = body[N-2];

  // Mark every bit that differs from the run polarity.
  for (genvar gi = 0; gi < N - 1; gi++) begin : g_diff
    assign diff[gi] = body[gi] ^ polarity;
  end

  // The highest differing bit terminates the run; no such bit means the run fills the word.
  always_comb begin
    run_len = RL_W'(N - 1);
    for (int i = 0; i <= N - 3; i++) begin
      if (diff[i]) run_len = RL_W'(N - 2 - i);
    end
  end

  // Skip the run plus its terminator; the extra shift bit keeps a full-word run from wrapping.
  assign shamt     = {1'b0, run_len} + (RL_W + 1)'(1);
  assign remainder = body << shamt;

endmodule

// File: rtl/posit_decode_pipe.sv
// Two-stage pipelined posit field decoder with valid/ready handshakes.
// Stage 1 captures sign, zero/NaR flags and the magnitude; stage 2 splits the
// regime, exponent and fraction. Optional feature macro: POSIT_DECODE_STATS_EN
// adds saturating NaR/zero transfer counters.
module posit_decode_pipe
  import posit_pkg::*;
#(
  parameter  int N       = 16,
  parameter  int ES      = 3,
  localparam int FRAC_W  = frac_w(N, ES),
  localparam int SCALE_W = scale_w(N, ES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N-1:0]              in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sign,
  output logic                      out_zero,
  output logic                      out_nar,
  output logic signed [SCALE_W-1:0] out_scale,
  output logic [FRAC_W-1:0]         out_frac
`ifdef POSIT_DECODE_STATS_EN
  ,
  output logic [15:0]               stat_nar_cnt,
  output logic [15:0]               stat_zero_cnt
`endif
);

  localparam int RL_W  = $clog2(N);
  localparam int EXP_W = (ES > 0) ? ES : 1;
  localparam logic [63:0]  NAR_WIDE = nar_pattern(N);
  localparam logic [N-1:0] NAR_WORD = NAR_WIDE[N-1:0];

  // Stage 1 state
  logic         s1_valid_q, s1_valid_d;
  logic         s1_sign_q, s1_sign_d;
  logic         s1_zero_q, s1_zero_d;
  logic         s1_nar_q, s1_nar_d;
  logic [N-1:0] s1_abs_q, s1_abs_d;

  // Stage 2 state (drives the outputs directly)
  logic                      s2_valid_q, s2_valid_d;
  logic                      s2_sign_q, s2_sign_d;
  logic                      s2_zero_q, s2_zero_d;
  logic                      s2_nar_q, s2_nar_d;
  logic signed [SCALE_W-1:0] s2_scale_q, s2_scale_d;
  logic [FRAC_W-1:0]         s2_frac_q, s2_frac_d;

  logic s2_load;
  logic s1_advance;

  logic [RL_W-1:0]           run_len;
  logic                      polarity;
  logic [N-2:0]              remainder;
  logic [EXP_W-1:0]          exp_bits;
  logic [FRAC_W-1:0]         frac_bits;
  logic signed [SCALE_W-1:0] run_ext;
  logic signed [SCALE_W-1:0] k_val;
  logic signed [SCALE_W-1:0] scale_calc;
  logic                      unused_rem;

  // Stage 2 can take new data when empty or when its contents leave this cycle.
  assign s2_load    = !s2_valid_q || out_ready;
  assign s1_advance = s1_valid_q && s2_load;
  assign in_ready   = !s1_valid_q || s1_advance;

  posit_regime_lzd #(.N(N)) u_lzd (
    .abs_in    (s1_abs_q),
    .run_len   (run_len),
    .polarity  (polarity),
    .remainder (remainder)
  );

  assign unused_rem = ^remainder;

  if (ES > 0) begin : g_exp
    assign exp_bits  = remainder[N-2 -: ES];
    assign frac_bits = remainder[N-2-ES -: FRAC_W];
  end else begin : g_no_exp
    assign exp_bits  = '0;
    assign frac_bits = remainder[N-2 -: FRAC_W];
  end

  // Regime value: a ones run of length r means k = r-1, a zeros run means k = -r.
  always_comb begin
    run_ext    = SCALE_W'(run_len);
    k_val      = polarity ? (run_ext - SCALE_W'(1)) : -run_ext;
    scale_calc = (k_val <<< ES) + SCALE_W'(exp_bits);
  end

  // Stage 1 next state: capture flags and two's-complement magnitude on acceptance.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_zero_d  = s1_zero_q;
    s1_nar_d   = s1_nar_q;
    s1_abs_d   = s1_abs_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d = in_data[N-1];
        s1_zero_d = (in_data == '0);
        s1_nar_d  = (in_data == NAR_WORD);
        s1_abs_d  = in_data[N-1] ? -in_data : in_data;
      end
    end
  end

  // Stage 2 next state: load decoded fields; zero and NaR report empty scale and fraction.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_zero_d  = s2_zero_q;
    s2_nar_d   = s2_nar_q;
    s2_scale_d = s2_scale_q;
    s2_frac_d  = s2_frac_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d  = s1_sign_q;
        s2_zero_d  = s1_zero_q;
        s2_nar_d   = s1_nar_q;
        s2_scale_d = (s1_zero_q || s1_nar_q) ? '0 : scale_calc;
        s2_frac_d  = (s1_zero_q || s1_nar_q) ? '0 : frac_bits;
      end
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_nar_q   <= 1'b0;
      s1_abs_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_nar_q   <= 1'b0;
      s2_scale_q <= '0;
      s2_frac_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_zero_q  <= s1_zero_d;
      s1_nar_q   <= s1_nar_d;
      s1_abs_q   <= s1_abs_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_zero_q  <= s2_zero_d;
      s2_nar_q   <= s2_nar_d;
      s2_scale_q <= s2_scale_d;
      s2_frac_q  <= s2_frac_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sign  = s2_sign_q;
  assign out_zero  = s2_zero_q;
  assign out_nar   = s2_nar_q;
  assign out_scale = s2_scale_q;
  assign out_frac  = s2_frac_q;

`ifdef POSIT_DECODE_STATS_EN
  logic [15:0] nar_cnt_q, nar_cnt_d;
  logic [15:0] zero_cnt_q, zero_cnt_d;
  logic        out_fire;

  assign out_fire = s2_valid_q && out_ready;

  // Count completed output transfers per flag, saturating at all-ones.
  always_comb begin
    nar_cnt_d  = nar_cnt_q;
    zero_cnt_d = zero_cnt_q;
    if (out_fire && s2_nar_q && (nar_cnt_q != 16'hFFFF))
      nar_cnt_d = nar_cnt_q + 16'd1;
    if (out_fire && s2_zero_q && (zero_cnt_q != 16'hFFFF))
      zero_cnt_d = zero_cnt_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nar_cnt_q  <= '0;
      zero_cnt_q <= '0;
    end else begin
      nar_cnt_q  <= nar_cnt_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

  assign stat_nar_cnt  = nar_cnt_q;
  assign stat_zero_cnt = zero_cnt_q;
`endif

endmodule
